// File: rtl/irq_controller.sv
// Prioritising interrupt controller: arbitrates masked level requests, raises a trap,
// waits for mret and then acknowledges the serviced line with a one-cycle pulse.
module irq_controller #(
    parameter int          IRQ_NUM     = 16,
    parameter logic [31:0] MCAUSE_BASE = 32'h8000_0010
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               stall_i,
    input  logic               exception_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        mcause_o,
    output logic [IRQ_NUM-1:0] irq_ret_o,
    output logic               busy_o,
    output logic [1:0]         state_o
);

    localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAP    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   sel_idx;
    logic [IRQ_NUM-1:0] masked;
    logic               unused_mie;

    // Only the mie bits that gate a request line matter here.
    assign masked     = irq_req_i & mie_i[16 +: IRQ_NUM];
    assign unused_mie = ^mie_i;

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        sel_idx = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (masked[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Trap handshake: irq_o acts as valid and !stall_i as ready; the trap is
    // transferred on the first cycle both are high, and until then irq_o and
    // mcause_o are held stable and cannot be withdrawn.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if ((|masked) && !exception_i) begin
                    idx_d   = sel_idx;
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP: begin
                if (!stall_i) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (mret_i) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs are decoded from registers only, so no input reaches them combinationally.
    assign irq_o     = (state_q == ST_TRAP);
    assign busy_o    = (state_q != ST_IDLE);
    assign mcause_o  = MCAUSE_BASE + 32'(idx_q);
    assign irq_ret_o = (state_q == ST_ACK) ? (IRQ_NUM'(1) << idx_q) : '0;
    assign state_o   = state_q;

endmodule
